vga_ctrl_param: RTL
===================

Name: vga_ctrl_param

Overview:
Parametrised VGA timing controller, the successor to the fixed 640x480 vga_ctrl. It generates raster counters, pixel addresses to an external pixel source (vmem or a future frame buffer) and sync/blank signals. Its delay pipeline matches the source's read latency, so RGB, sync and valid always leave aligned. Sits between the pixel source and the VGA_* pins in top.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 8, bits per colour channel
DATA_LAT, 0, read latency of pixel source in clocks, 0..4 (0 = combinational, as vmem)

Ports:
clk  in  1  pixel clock, single clock domain
rst  in  1  reset, synchronous, active-high
en  in  1  advance raster; 0 stalls counters and pipeline
vga_data  in  3*CW  pixel {R,G,B} returned by source
h_addr  out  10  pixel column to source (0 outside active)
v_addr  out  10  pixel row to source (0 outside active)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
valid  out  1  active-video (drives VGA_BLANK_N)
vga_r  out  CW  red
vga_g  out  CW  green
vga_b  out  CW  blue
frame_start  out  1  1-cycle pulse with output pixel (0,0)
vblank  out  1  high while output line >= V_ACTIVE

Behaviour:
- Line and frame totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Segment order on each axis: active, FP, sync, BP.
- h_cnt counts 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
- At v_cnt = V_TOTAL-1 with h wrap, both counters go to 0 on the same edge.
- Address stage: h_addr and v_addr are registered. In cycle t they present h_cnt and v_cnt when both are active, else 0.
- Source contract: the source returns vga_data for that address at cycle t+DATA_LAT.
- Output stage: hsync, vsync, valid, RGB, frame_start and vblank for the pixel addressed at cycle t are registered at t+DATA_LAT+1.
- Per-pixel control bits (active, hs, vs, first, vb) pass through a DATA_LAT-deep shift register.
- hsync = HS_POL while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; else ~HS_POL. vsync follows the same rule on v_cnt with VS_POL.
- RGB equals vga_data slices when valid=1. It is forced to 0 when valid=0.
- en=0: counters, address regs, delay pipe and all outputs hold their value. When en returns to 1, the sequence resumes with no skipped or repeated pixel.
- Reset values, on the cycle after rst is sampled high:
  - counters 0, h_addr 0, v_addr 0
  - hsync=~HS_POL, vsync=~VS_POL
  - valid 0, RGB 0, frame_start 0, vblank 0
  - delay pipe cleared to the inactive, non-sync state
- Reset mid-frame: the same clean restart applies. The first cycle with rst=0 and en=1 drives address (0,0).
- frame_start fires exactly once per frame, including the first frame after reset.
- Width rule: H_TOTAL and V_TOTAL must be <= 1024. The block checks this at elaboration and stops if it is exceeded.

Optional Feature:
VGA_TESTPAT_EN:
- Defined: adds input test_mode (1 bit).
- When test_mode=1, RGB comes from an internal 8-bar generator that ignores vga_data. Bar index is (h*8)/H_ACTIVE. Bar colour is {R,G,B} = {idx[2],idx[1],idx[0]}, each bit replicated to CW bits.
- Latency, valid and sync are identical to normal mode. test_mode is sampled at the address stage and pipelined with the pixel.
- Undefined: no test_mode port; RGB always comes from vga_data.

Test Plan:
1. Defaults, DATA_LAT=0, en=1 after reset:
   - hsync low for h in 656..751 (96 clocks) every 800 clocks.
   - vsync low for lines 490..491.
   - frame period 420000 clocks; valid high for 640 clocks per active line.
2. Alignment, DATA_LAT=2, source model returning {h_addr[7:0], v_addr[7:0], 8'hA5} after 2 clocks:
   - Every valid output pixel matches its own coordinates.
   - First valid RGB appears 3 clocks after h_addr=0,v_addr=0.
3. Small timing (H 8/1/2/1, V 4/1/1/1):
   - h wrap 11->0 increments v; v 6 with h wrap -> (0,0).
   - frame_start pulses every 84 clocks.
   - vblank high for lines 4..6.
4. Stall: drop en for 5 clocks at h=300, v=100.
   - All outputs frozen for 5 clocks.
   - Next address after resume is (301,100); no pixel lost.
5. Reset mid-frame at h=400, v=250:
   - Next cycle valid=0, RGB=0, hsync=1, vsync=1.
   - First post-reset address is (0,0); frame_start reappears DATA_LAT+1 clocks later.
6. With VGA_TESTPAT_EN, test_mode=1, defaults:
   - pixel 0 RGB = 000000.
   - pixel 80 RGB = 0000FF.
   - pixel 639 RGB = FFFFFF.
   - vga_data ignored.

Source files
------------

// File: rtl/vga_ctrl_param_if.sv
// vga_ctrl_param_if: pixel-source bus between the timing controller
// and the pixel source (address out, {R,G,B} back).
interface vga_ctrl_param_if #(
  parameter int CW = 8
);
  logic [9:0]      h_addr;
  logic [9:0]      v_addr;
  logic [3*CW-1:0] vga_data;

  modport master (
    output h_addr,
    output v_addr,
    input  vga_data
  );

  modport slave (
    input  h_addr,
    input  v_addr,
    output vga_data
  );
endinterface

// File: rtl/vga_ctrl_param.sv
// vga_ctrl_param: parametrised VGA raster, sync and latency-matched RGB.
// Define VGA_TESTPAT_EN to add test_mode and the 8-bar test pattern.
module vga_ctrl_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8,
  parameter int DATA_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  vga_ctrl_param_if.master src,
`ifdef VGA_TESTPAT_EN
  input  logic          test_mode,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [CW-1:0] vga_r,
  output logic [CW-1:0] vga_g,
  output logic [CW-1:0] vga_b,
  output logic          frame_start,
  output logic          vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $fatal(1, "vga_ctrl_param: line/frame total exceeds 1024");
  end

  if (DATA_LAT < 0 || DATA_LAT > 4) begin : g_lat_chk
    $fatal(1, "vga_ctrl_param: DATA_LAT must be 0..4");
  end

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON = HS_POL[0];
  localparam logic VS_ON = VS_POL[0];

  // Sync bits travel as "in sync" flags; all-zero is the idle state.
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       first;
    logic       vb;
    logic       tm;
    logic [2:0] bar;
  } ctrl_t;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  logic       tm_now;
  logic [2:0] bar_now;

`ifdef VGA_TESTPAT_EN
  assign tm_now  = test_mode;
  assign bar_now = 3'(({3'b000, h_cnt} << 3) / 13'(H_ACTIVE));
`else
  assign tm_now  = 1'b0;
  assign bar_now = 3'b000;
`endif

  ctrl_t c_now;

  always_comb begin
    c_now       = '0;
    c_now.act   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    c_now.hs    = (h_cnt >= HS_BEG) && (h_cnt <= HS_LAST);
    c_now.vs    = (v_cnt >= VS_BEG) && (v_cnt <= VS_LAST);
    c_now.first = (h_cnt == '0) && (v_cnt == '0);
    c_now.vb    = (v_cnt >= V_ACT);
    c_now.tm    = tm_now;
    c_now.bar   = bar_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src.h_addr <= '0;
      src.v_addr <= '0;
    end else if (en) begin
      src.h_addr <= c_now.act ? h_cnt : '0;
      src.v_addr <= c_now.act ? v_cnt : '0;
    end
  end

  // pipe[0] rides with the address; pipe[DATA_LAT] meets vga_data.
  ctrl_t pipe [DATA_LAT+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DATA_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else if (en) begin
      pipe[0] <= c_now;
      for (int i = 1; i <= DATA_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  ctrl_t           c_out;
  logic [3*CW-1:0] pix;

  assign c_out = pipe[DATA_LAT];

  always_comb begin
    pix = src.vga_data;
    if (c_out.tm) begin
      pix = {{CW{c_out.bar[2]}},
             {CW{c_out.bar[1]}},
             {CW{c_out.bar[0]}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      valid       <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (en) begin
      hsync       <= c_out.hs ? HS_ON : ~HS_ON;
      vsync       <= c_out.vs ? VS_ON : ~VS_ON;
      valid       <= c_out.act;
      vga_r       <= c_out.act ? pix[3*CW-1:2*CW] : '0;
      vga_g       <= c_out.act ? pix[2*CW-1:CW] : '0;
      vga_b       <= c_out.act ? pix[CW-1:0] : '0;
      frame_start <= c_out.first;
      vblank      <= c_out.vb;
    end
  end

endmodule
